// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, decode handshake and
// redirect/halt controls. The fetch unit is the master; its environment is the slave.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, in-order imem reads with tag queue, DEPTH-entry FIFO to decode.
// Optional counters (fetched/stall/flush) enabled by defining IFETCH_STATS_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_OUT  = 2
) (
  input logic          clk,
  input logic          rstn,
  inst_fetch_if.master bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_stall,
  output logic [31:0]  stat_flush
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;
  localparam logic [TW-1:0] TLAST = TW'(MAX_OUT - 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [OW-1:0]   outstanding, drop;
  logic [CW-1:0]   count, after_pop;
  logic [AW-1:0]   rd_ptr, wr_ptr, head_idx;
  logic [TW-1:0]   tag_rd, tag_wr;
  logic [31:0]     fifo_inst [DEPTH];
  logic [31:0]     fifo_pc   [DEPTH];
  logic [31:0]     tag_pc    [MAX_OUT];
  logic [31:0]     inst_q, inst_pc_q;
  logic [SW-1:0]   in_use;
  logic            req, grant, rsp, push, pop, valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  // Credit counts FIFO entries plus live (non-dropped) in-flight words.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      RUN:     if (bus.halt)  state_nxt = HOLD;
      HOLD:    if (!bus.halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    in_use = SW'(count) + SW'(outstanding) - SW'(drop);
    req    = rstn && (state == RUN) && (outstanding < OW'(MAX_OUT))
             && (in_use < SW'(DEPTH)) && !bus.redirect;
  end

  assign grant     = req && bus.imem_gnt;
  assign rsp       = bus.imem_rvalid && (outstanding != '0);
  assign push      = rsp && (drop == '0) && !bus.redirect;
  assign valid     = (count != '0);
  assign pop       = valid && bus.inst_ready && !bus.redirect;
  assign after_pop = count - CW'(pop);
  assign head_idx  = rd_ptr + AW'(pop);

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc & ~32'h3;
  assign bus.inst_valid = valid;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
    end else begin
      if (grant) tag_wr <= (tag_wr == TLAST) ? '0 : tag_wr + TW'(1);
      if (rsp)   tag_rd <= (tag_rd == TLAST) ? '0 : tag_rd + TW'(1);
      if (bus.redirect) begin
        pc          <= bus.redirect_pc & ~32'h3;
        outstanding <= outstanding - OW'(rsp);
        drop        <= outstanding - OW'(rsp);
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (grant) pc <= pc + 32'd4;
        outstanding <= outstanding + OW'(grant) - OW'(rsp);
        if (rsp && (drop != '0)) drop <= drop - OW'(1);
        count <= after_pop + CW'(push);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= head_idx;
        // Output register follows the next head; a push into an emptied FIFO bypasses storage.
        if ((after_pop != '0) || push) begin
          inst_q    <= (after_pop == '0) ? bus.imem_rdata   : fifo_inst[head_idx];
          inst_pc_q <= (after_pop == '0) ? tag_pc[tag_rd]   : fifo_pc[head_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_pc[tag_wr] <= bus.imem_addr;
    if (push) begin
      fifo_inst[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    push |-> ((count < CW'(DEPTH)) || pop));

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
      stat_flush   <= '0;
    end else begin
      if (pop && (stat_fetched != '1))                      stat_fetched <= stat_fetched + 32'd1;
      if (valid && !bus.inst_ready && (stat_stall != '1))   stat_stall   <= stat_stall + 32'd1;
      if (bus.redirect && (stat_flush != '1))               stat_flush   <= stat_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-level model of the fetch stream checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] fifo_m [$];
  logic [31:0] log_pc [$];
  pend_t       pend [$];
  int          out_m, drop_m;
  logic [31:0] m_pc;
  bit          m_hold;
  int          lat;
  int          cyc = 0;
  logic [31:0] rv_addr;
  bit          g_cap;
  logic [31:0] a_cap;
  logic [31:0] last_inst, last_pc;
  int          first_gnt, first_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_req();
    return rstn && !m_hold && (out_m < MAX_OUT)
           && ((fifo_m.size() + out_m - drop_m) < DEPTH) && !bus.redirect;
  endfunction

  function automatic logic [31:0] logged(input int i);
    return (log_pc.size() > i) ? log_pc[i] : 32'hDEAD_DEAD;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rstn) begin
      last_inst   = '0;
      last_pc     = '0;
      first_gnt   = -1;
      first_valid = -1;
    end
    g_cap = exp_req() && bus.imem_gnt;
    a_cap = m_pc;
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req()});
    check("imem_addr", bus.imem_addr, m_pc);
    check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, fifo_m.size() > 0});
    if (fifo_m.size() > 0) begin
      check("inst_pc", bus.inst_pc, fifo_m[0]);
      check("inst", bus.inst, ~fifo_m[0]);
      last_pc   = fifo_m[0];
      last_inst = ~fifo_m[0];
      if (first_valid < 0 && first_gnt >= 0) first_valid = cyc;
    end else begin
      check("inst_pc_hold", bus.inst_pc, last_pc);
      check("inst_hold", bus.inst, last_inst);
    end
    if (g_cap && first_gnt < 0) first_gnt = cyc;
  end

  // Model update: spec rules applied to queues and counters
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_m  = 0;
      drop_m = 0;
      fifo_m.delete();
      m_pc   = RESET_PC;
      m_hold = 1'b0;
    end else begin
      automatic bit rv  = bus.imem_rvalid && (out_m > 0);
      automatic bit pop = (fifo_m.size() > 0) && bus.inst_ready;
      if (bus.redirect) begin
        if (rv) out_m--;
        drop_m = out_m;
        fifo_m.delete();
        m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (pop) log_pc.push_back(fifo_m.pop_front());
        if (rv) begin
          out_m--;
          if (drop_m > 0) drop_m--;
          else            fifo_m.push_back(rv_addr);
        end
        if (g_cap) begin
          out_m++;
          m_pc = m_pc + 32'd4;
        end
      end
      m_hold = bus.halt;
    end
  end

  // Instruction memory: in-order responses after a fixed latency, data = ~addr
  always @(posedge clk) begin
    if (g_cap && rstn) pend.push_back('{addr: a_cap, due: cyc + lat});
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = ~pend[0].addr;
      rv_addr         = pend[0].addr;
      void'(pend.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    #1;
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_addr", bus.imem_addr, RESET_PC);
    tick(n);
    rstn = 1'b1;
  endtask

  task automatic drain(input int new_lat);
    int k = 0;
    bus.halt = 1'b1;
    while ((pend.size() != 0 || out_m != 0) && k < 60) begin
      tick(1);
      k++;
    end
    check("drain_bound", {31'b0, k < 60}, 32'd1);
    lat = new_lat;
    bus.halt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, k;
    bus.imem_gnt    = 1'b1;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
    lat = 1;
    rstn = 1'b1;
    #1;
    do_reset(2);

    // Decoder stalled: exactly DEPTH words buffered, head stable
    tick(6);
    check("stall_req", {31'b0, bus.imem_req}, 32'd0);
    check("stall_inst_pc", bus.inst_pc, 32'h0000_0000);
    check("stall_inst", bus.inst, 32'hFFFF_FFFF);
    check("stall_addr", bus.imem_addr, 32'h0000_0008);
    check("stall_buffered", fifo_m.size(), 32'd2);
    check("first_latency", first_valid - first_gnt, 32'd2);
    bus.inst_ready = 1'b1;
    tick(8);
    check("seq0", logged(0), 32'h0000_0000);
    check("seq1", logged(1), 32'h0000_0004);
    check("seq2", logged(2), 32'h0000_0008);
    bus.imem_gnt = 1'b0;
    tick(2);
    bus.imem_gnt = 1'b1;
    tick(4);

    // Redirect with two requests in flight on a 3-cycle memory
    drain(3);
    k = 0;
    while (out_m != 2 && k < 20) begin tick(1); k++; end
    check("two_outstanding", {31'b0, k < 20}, 32'd1);
    base = log_pc.size();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    tick(1);
    bus.redirect = 1'b0;
    tick(14);
    check("redir_first", logged(base), 32'h0000_0100);
    check("redir_second", logged(base + 1), 32'h0000_0104);

    // Redirect coinciding with a response and a pop, unaligned target
    drain(1);
    k = 0;
    while (!(bus.imem_rvalid && fifo_m.size() > 0) && k < 20) begin tick(1); k++; end
    check("rv_pop_found", {31'b0, k < 20}, 32'd1);
    base = log_pc.size();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    tick(1);
    bus.redirect = 1'b0;
    check("align_addr", bus.imem_addr, 32'h0000_0200);
    check("flush_valid", {31'b0, bus.inst_valid}, 32'd0);
    tick(8);
    check("align_first", logged(base), 32'h0000_0200);

    // PC wrap at the top of the address space
    base = log_pc.size();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick(1);
    bus.redirect = 1'b0;
    tick(12);
    check("wrap0", logged(base), 32'hFFFF_FFF8);
    check("wrap1", logged(base + 1), 32'hFFFF_FFFC);
    check("wrap2", logged(base + 2), 32'h0000_0000);

    // Halt with responses in flight
    drain(3);
    tick(5);
    bus.halt = 1'b1;
    base = log_pc.size();
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("halt_req", {31'b0, bus.imem_req}, 32'd0);
      tick(1);
    end
    check("halt_landed", {31'b0, log_pc.size() > base}, 32'd1);
    bus.halt = 1'b0;
    tick(8);

    // Reset in the middle of a burst; stale responses must be ignored
    tick(2);
    do_reset(5);
    #1;
    check("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
    check("post_rst_addr", bus.imem_addr, RESET_PC);
    base = log_pc.size();
    tick(12);
    check("post_rst_first", logged(base), RESET_PC);
    check("post_rst_second", logged(base + 1), RESET_PC + 32'd4);

    drain(1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues in-order word reads to instruction memory.
- Buffers returned words in a small FIFO and presents {inst, pc} to decode through a valid/ready handshake.
- Accepts redirects (branch/jump) from later stages and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- DEPTH, 2, instruction FIFO entries (power of two, >=2).
- MAX_OUT, 2, maximum outstanding memory requests (1..DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  32  word-aligned fetch address; bits[1:0] always 0.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  FIFO head valid to decoder.
- inst  output  32  instruction word at FIFO head.
- inst_pc  output  32  address of inst.
- inst_ready  input  1  decoder consumes head when inst_valid && inst_ready.
- redirect  input  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  input  32  new PC; bits[1:0] forced to 0.
- halt  input  1  level: stop issuing new requests while high.

Behaviour:
- Reset (async, rstn low): pc=RESET_PC, FIFO empty, outstanding=0, drop=0, state=RUN; imem_req=0, inst_valid=0, inst=0, inst_pc=0, imem_addr=RESET_PC.
- Reset mid-operation: all of the above apply immediately. Responses arriving after reset are not counted as outstanding and are ignored.
- FSM states:
  - RUN: issue requests.
  - HOLD: halt high, no issue.
  - RUN->HOLD when halt=1; HOLD->RUN when halt=0.
  - redirect is legal in both states and does not change state.
- Issue rule: imem_req=1 iff all of the following hold:
  - state==RUN;
  - outstanding < MAX_OUT;
  - fifo_count + outstanding - drop < DEPTH (credit check);
  - redirect==0.
- imem_addr=pc.
- On imem_req && imem_gnt: pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); outstanding +1.
- Each in-flight request carries its PC in a MAX_OUT-deep in-order tag queue.
- On imem_rvalid: outstanding -1.
  - If drop>0: drop -1, word discarded.
  - Else: push {imem_rdata, tag_pc} into FIFO.
- Latency: grant in cycle N, rvalid in cycle N+k → inst_valid no earlier than cycle N+k+1 (registered FIFO output).
- Pop: inst_valid && inst_ready removes head. Simultaneous push and pop with the FIFO full is legal; the count is unchanged.
- Push while full cannot occur by the credit rule; the assertion checks it.
- Redirect (takes priority over every other same-cycle event):
  - FIFO flushed (inst_valid=0 next cycle); a same-cycle pop is also discarded.
  - pc <= {redirect_pc[31:2],2'b00}.
  - drop <= outstanding after applying this cycle's events. A grant in the redirect cycle cannot happen since imem_req=0. A same-cycle rvalid is itself discarded.
  - First request at the new pc issues the cycle after the redirect.
- inst/inst_pc hold their last values when inst_valid=0. Outputs are stable while inst_valid && !inst_ready.

Optional Feature:
- Macro: IFETCH_STATS_EN.
- When defined: adds outputs stat_fetched[31:0] (FIFO pops), stat_stall[31:0] (cycles with inst_valid && !inst_ready), and stat_flush[31:0] (redirect pulses).
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1 → requests at 0x0,0x4,0x8…; inst_pc sequence 0x0,0x4,0x8 with matching rdata; first inst_valid 2 cycles after first grant.
- Hold inst_ready=0 → exactly DEPTH=2 words buffered, imem_req drops to 0, inst/inst_pc stable. Release → pops 0x0,0x4 in order, then fetching resumes at 0x8.
- 3-cycle memory latency, MAX_OUT=2, pulse redirect to 0x100 with 2 requests outstanding → both late responses dropped; next inst_pc=0x100; no stale pc seen.
- Redirect to 0x203 in the same cycle as an rvalid and a pop → imem_addr=0x200; the rvalid word and popped entry are discarded; FIFO empty next cycle.
- PC at 0xFFFF_FFFC granted → next imem_addr=0x0000_0000.
- halt=1 for 5 cycles → no imem_req; outstanding responses still land in the FIFO. halt=0 → issue resumes at the next sequential pc.
- Assert rstn low mid-burst → outputs reset immediately; first post-reset request at RESET_PC.
